lsm: RTL and testbench

- Load/store memory stage of the ECAP5-DPROC pipeline.
- Sits between the execute stage and the write-back stage.
- Acts as the data-side Wishbone (pipelined) master that drives the external memory arbiter's second slave port. The arbiter's first port is instruction fetch.
- Non-memory instructions pass through to write-back with one-cycle latency. Loads and stores run a single Wishbone transaction each, with byte-lane alignment and sign/zero extension.

---
 rtl/ecap5_dproc_pkg.sv | 17 +
 rtl/lsm_align.sv | 43 ++++
 rtl/lsm.sv | 178 +++++++++++++++++
 tb/tb_lsm.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecap5_dproc_pkg.sv
// Shared types for the ECAP5-DPROC load/store path: access sizes and the
// load/store FSM state encoding.
package ecap5_dproc_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    WAIT    = 2'd2
  } lsm_state_t;

endpackage

// File: rtl/lsm_align.sv
// Byte-lane helper for the load/store stage: lane select, store data
// replication and load extraction with sign/zero extension.
// Size 3 is reserved and handled as a word. Misaligned halves/words are
// aligned down by ignoring the low offset bits.
module lsm_align
  import ecap5_dproc_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sext,
  input  logic [31:0] store_data,
  input  logic [31:0] load_raw,
  output logic [3:0]  sel,
  output logic [31:0] store_rep,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Lane mapping per access size; words use the raw bus data unchanged
  always_comb begin
    sel       = 4'b1111;
    store_rep = store_data;
    shifted   = load_raw;
    load_data = shifted;
    case (size)
      MEM_BYTE: begin
        sel       = 4'b0001 << offset;
        store_rep = {4{store_data[7:0]}};
        shifted   = load_raw >> {offset, 3'b000};
        load_data = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      MEM_HALF: begin
        sel       = 4'b0011 << {offset[1], 1'b0};
        store_rep = {2{store_data[15:0]}};
        shifted   = load_raw >> {offset[1], 4'b0000};
        load_data = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsm.sv
// Load/store memory stage: passes ALU results to write-back with one cycle
// of latency and runs one pipelined Wishbone transaction per load/store.
// Optional build macro LSM_MISALIGN_EXC_EN: misaligned accesses raise an
// exception (misaligned_o, exc_addr_o) instead of being aligned down.
module lsm
  import ecap5_dproc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        input_valid_i,
  output logic        input_ready_o,
  input  logic        enable_i,
  input  logic        write_i,
  input  logic        sext_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        reg_write_i,
  input  logic [4:0]  reg_addr_i,
  output logic        output_valid_o,
  output logic        reg_write_o,
  output logic [4:0]  reg_addr_o,
  output logic [31:0] reg_data_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i
`ifdef LSM_MISALIGN_EXC_EN
  ,
  output logic        misaligned_o,
  output logic [31:0] exc_addr_o
`endif
);

  lsm_state_t  state, state_next;
  logic        accept, mem_go;
  logic [1:0]  size_p1, off_p1;
  logic        sext_p1, we_p1, rw_p1;
  logic [4:0]  rd_p1;
  logic [1:0]  al_size, al_off;
  logic        al_sext;
  logic [3:0]  al_sel;
  logic [31:0] al_wdat, al_rdat;

  assign accept = input_valid_i && input_ready_o;

`ifdef LSM_MISALIGN_EXC_EN
  logic misaligned;
  assign misaligned = ((size_i == MEM_HALF) && addr_i[0]) ||
                      (size_i[1] && (addr_i[1:0] != 2'b00));
  assign mem_go = accept && enable_i && !misaligned;
`else
  assign mem_go = accept && enable_i;
`endif

  // In IDLE the aligner shapes the incoming request; afterwards it decodes
  // the read data using the fields latched at accept time.
  assign al_size = (state == IDLE) ? size_i     : size_p1;
  assign al_off  = (state == IDLE) ? addr_i[1:0] : off_p1;
  assign al_sext = (state == IDLE) ? sext_i     : sext_p1;

  lsm_align u_align (
    .size       (al_size),
    .offset     (al_off),
    .sext       (al_sext),
    .store_data (data_i),
    .load_raw   (wb_dat_i),
    .sel        (al_sel),
    .store_rep  (al_wdat),
    .load_data  (al_rdat)
  );

  // Next-state logic: one request phase, one wait-for-ack phase
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_go)      state_next = REQUEST;
      REQUEST: if (!wb_stall_i) state_next = WAIT;
      WAIT:    if (wb_ack_i)    state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  // p0 -> p1: instruction fields needed while the bus cycle is in flight
  always_ff @(posedge clk_i) begin
    if (mem_go) begin
      size_p1 <= size_i;
      off_p1  <= addr_i[1:0];
      sext_p1 <= sext_i;
      we_p1   <= write_i;
      rw_p1   <= reg_write_i;
      rd_p1   <= reg_addr_i;
    end
  end

  // Registered bus and write-back outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      input_ready_o  <= 1'b1;
      output_valid_o <= 1'b0;
      reg_write_o    <= 1'b0;
      reg_addr_o     <= 5'd0;
      reg_data_o     <= 32'd0;
      wb_adr_o       <= 32'd0;
      wb_dat_o       <= 32'd0;
      wb_we_o        <= 1'b0;
      wb_sel_o       <= 4'd0;
      wb_stb_o       <= 1'b0;
      wb_cyc_o       <= 1'b0;
`ifdef LSM_MISALIGN_EXC_EN
      misaligned_o   <= 1'b0;
      exc_addr_o     <= 32'd0;
`endif
    end else begin
      output_valid_o <= 1'b0;
`ifdef LSM_MISALIGN_EXC_EN
      misaligned_o   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            if (!enable_i) begin
              output_valid_o <= 1'b1;
              reg_write_o    <= reg_write_i;
              reg_addr_o     <= reg_addr_i;
              reg_data_o     <= data_i;
            end
`ifdef LSM_MISALIGN_EXC_EN
            else if (misaligned) begin
              output_valid_o <= 1'b1;
              reg_write_o    <= 1'b0;
              reg_addr_o     <= reg_addr_i;
              reg_data_o     <= 32'd0;
              misaligned_o   <= 1'b1;
              exc_addr_o     <= addr_i;
            end
`endif
            else begin
              input_ready_o <= 1'b0;
              wb_cyc_o      <= 1'b1;
              wb_stb_o      <= 1'b1;
              wb_adr_o      <= {addr_i[31:2], 2'b00};
              wb_dat_o      <= al_wdat;
              wb_sel_o      <= al_sel;
              wb_we_o       <= write_i;
            end
          end
        end
        REQUEST: begin
          if (!wb_stall_i) wb_stb_o <= 1'b0;
        end
        WAIT: begin
          if (wb_ack_i) begin
            wb_cyc_o       <= 1'b0;
            input_ready_o  <= 1'b1;
            output_valid_o <= 1'b1;
            reg_write_o    <= rw_p1 && !we_p1;
            reg_addr_o     <= rd_p1;
            reg_data_o     <= we_p1 ? 32'd0 : al_rdat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsm.sv
// Self-checking bench for lsm: directed table, hand sequences for the
// multi-cycle corners, and randomized transactions against a behavioural model.
module tb_lsm;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        input_valid_i, input_ready_o, enable_i, write_i, sext_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, data_i;
  logic        reg_write_i;
  logic [4:0]  reg_addr_i;
  logic        output_valid_o, reg_write_o;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_o, wb_adr_o, wb_dat_i, wb_dat_o;
  logic        wb_we_o, wb_stb_o, wb_ack_i, wb_cyc_o, wb_stall_i;
  logic [3:0]  wb_sel_o;
`ifdef LSM_MISALIGN_EXC_EN
  logic        misaligned_o;
  logic [31:0] exc_addr_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  lsm dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .input_valid_i(input_valid_i), .input_ready_o(input_ready_o),
    .enable_i(enable_i), .write_i(write_i), .sext_i(sext_i), .size_i(size_i),
    .addr_i(addr_i), .data_i(data_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
    .output_valid_o(output_valid_o), .reg_write_o(reg_write_o),
    .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o),
    .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
    .wb_cyc_o(wb_cyc_o), .wb_stall_i(wb_stall_i)
`ifdef LSM_MISALIGN_EXC_EN
    , .misaligned_o(misaligned_o), .exc_addr_o(exc_addr_o)
`endif
  );

  typedef struct {
    logic        wr;
    logic        sext;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdat;
    logic [4:0]  rd;
    int          nstall;
    int          dly;
    logic        noise;
    logic [3:0]  e_sel;
    logic [31:0] e_adr;
    logic [31:0] e_dat;
    logic [31:0] e_reg;
    logic        e_rw;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: byte enables from size and address
  function automatic logic [3:0] m_sel(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return 4'(1 << a[1:0]);
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Behavioural model: store data copied into every lane of its size
  function automatic logic [31:0] m_wdat(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    return {24'd0, d[7:0]} * 32'h0101_0101;
      2'd1:    return {16'd0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Behavioural model: pick the addressed byte/half and extend it
  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                         input logic sx, input logic [31:0] raw);
    int unsigned v;
    case (sz)
      2'd0: begin
        v = (raw >> (8 * int'(a[1:0]))) & 32'hFF;
        if (sx && v >= 128) v = v - 256;
      end
      2'd1: begin
        v = (raw >> (16 * int'(a[1]))) & 32'hFFFF;
        if (sx && v >= 32768) v = v - 65536;
      end
      default: v = raw;
    endcase
    return v;
  endfunction

  function automatic vec_t mk(input logic wr, input logic sx, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] rdat, input int ns, input int dly,
                              input logic [3:0] esel, input logic [31:0] eadr,
                              input logic [31:0] edat, input logic [31:0] ereg);
    vec_t v;
    v.wr = wr; v.sext = sx; v.size = sz; v.addr = a; v.data = d; v.rdat = rdat;
    v.rd = 5'(a[6:2] | 5'd1); v.nstall = ns; v.dly = dly; v.noise = 1'b0;
    v.e_sel = esel; v.e_adr = eadr; v.e_dat = edat; v.e_reg = ereg; v.e_rw = !wr;
    return v;
  endfunction

  task automatic idle_inputs();
    input_valid_i = 1'b0; enable_i = 1'b0; write_i = 1'b0; sext_i = 1'b0;
    size_i = 2'd0; addr_i = 32'd0; data_i = 32'd0; reg_write_i = 1'b0;
    reg_addr_i = 5'd0; wb_dat_i = 32'd0; wb_ack_i = 1'b0; wb_stall_i = 1'b0;
  endtask

  // One memory instruction, playing the Wishbone slave cycle by cycle
  task automatic run_txn(input vec_t v);
    n_vec++;
    @(negedge clk_i);
    chk("ready_before_accept", input_ready_o, 1);
    input_valid_i = 1'b1; enable_i = 1'b1; write_i = v.wr; sext_i = v.sext;
    size_i = v.size; addr_i = v.addr; data_i = v.data; reg_write_i = 1'b1;
    reg_addr_i = v.rd; wb_stall_i = 1'b0; wb_ack_i = 1'b0;
    for (int k = 0; k <= v.nstall; k++) begin
      @(negedge clk_i);
      if (k == 0) begin
        input_valid_i = 1'b0;
        addr_i = $urandom; data_i = $urandom; size_i = 2'($urandom_range(0, 3));
        sext_i = 1'($urandom_range(0, 1)); write_i = 1'($urandom_range(0, 1));
      end
      chk("req_cyc", wb_cyc_o, 1);
      chk("req_stb", wb_stb_o, 1);
      chk("req_adr", wb_adr_o, v.e_adr);
      chk("req_sel", wb_sel_o, v.e_sel);
      chk("req_we", wb_we_o, v.wr);
      if (v.wr) chk("req_dat", wb_dat_o, v.e_dat);
      chk("req_ready", input_ready_o, 0);
      chk("req_valid", output_valid_o, 0);
      wb_stall_i = (k < v.nstall);
      wb_ack_i = v.noise ? 1'($urandom_range(0, 1)) : 1'b0;
      wb_dat_i = $urandom;
    end
    wb_stall_i = 1'b0; wb_ack_i = 1'b0;
    for (int j = 0; j <= v.dly; j++) begin
      @(negedge clk_i);
      chk("wait_stb", wb_stb_o, 0);
      chk("wait_cyc", wb_cyc_o, 1);
      chk("wait_ready", input_ready_o, 0);
      chk("wait_valid", output_valid_o, 0);
      wb_ack_i = (j == v.dly);
      wb_dat_i = (j == v.dly) ? v.rdat : $urandom;
    end
    @(negedge clk_i);
    wb_ack_i = 1'b0; wb_dat_i = $urandom;
    chk("done_valid", output_valid_o, 1);
    chk("done_cyc", wb_cyc_o, 0);
    chk("done_ready", input_ready_o, 1);
    chk("done_reg_write", reg_write_o, v.e_rw);
    chk("done_reg_addr", reg_addr_o, v.rd);
    if (!v.wr) chk("done_reg_data", reg_data_o, v.e_reg);
    @(negedge clk_i);
    chk("valid_pulse_end", output_valid_o, 0);
  endtask

  // One non-memory instruction
  task automatic run_alu(input logic [31:0] d, input logic [4:0] rd, input logic rw);
    n_vec++;
    @(negedge clk_i);
    input_valid_i = 1'b1; enable_i = 1'b0; data_i = d; reg_addr_i = rd; reg_write_i = rw;
    @(negedge clk_i);
    input_valid_i = 1'b0;
    chk("alu_valid", output_valid_o, 1);
    chk("alu_data", reg_data_o, d);
    chk("alu_rd", reg_addr_o, rd);
    chk("alu_rw", reg_write_o, rw);
    chk("alu_cyc", wb_cyc_o, 0);
    @(negedge clk_i);
    chk("alu_valid_end", output_valid_o, 0);
  endtask

  vec_t tbl[9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    tbl[0] = mk(0, 1, 2'd0, 32'h103, 32'h0,         32'h80AA_BBCC, 0, 0, 4'b1000, 32'h100, 32'h0,         32'hFFFF_FF80);
    tbl[1] = mk(1, 0, 2'd1, 32'h202, 32'h1234_5678, 32'h0,         3, 0, 4'b1100, 32'h200, 32'h5678_5678, 32'h0);
    tbl[2] = mk(0, 0, 2'd2, 32'h300, 32'h0,         32'hDEAD_BEEF, 0, 5, 4'b1111, 32'h300, 32'h0,         32'hDEAD_BEEF);
    tbl[3] = mk(0, 0, 2'd1, 32'h402, 32'h0,         32'h8765_4321, 0, 1, 4'b1100, 32'h400, 32'h0,         32'h0000_8765);
    tbl[4] = mk(0, 1, 2'd1, 32'h400, 32'h0,         32'h1234_F00D, 1, 0, 4'b0011, 32'h400, 32'h0,         32'hFFFF_F00D);
    tbl[5] = mk(1, 0, 2'd0, 32'h501, 32'h0000_00AB, 32'h0,         0, 0, 4'b0010, 32'h500, 32'hABAB_ABAB, 32'h0);
    tbl[6] = mk(0, 1, 2'd0, 32'h602, 32'h0,         32'h00C3_0000, 0, 0, 4'b0100, 32'h600, 32'h0,         32'hFFFF_FFC3);
    tbl[7] = mk(1, 0, 2'd2, 32'h700, 32'hCAFE_F00D, 32'h0,         1, 2, 4'b1111, 32'h700, 32'hCAFE_F00D, 32'h0);
    tbl[8] = mk(0, 1, 2'd3, 32'h800, 32'h0,         32'h9122_3344, 0, 0, 4'b1111, 32'h800, 32'h0,         32'h9122_3344);

    idle_inputs();
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", input_ready_o, 1);
    chk("rst_valid", output_valid_o, 0);
    chk("rst_reg_write", reg_write_o, 0);
    chk("rst_reg_addr", reg_addr_o, 0);
    chk("rst_reg_data", reg_data_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_sel", wb_sel_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_cyc", wb_cyc_o, 0);
    rst_i = 1'b1;

    // Back-to-back non-memory burst, one result per cycle
    n_vec++;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk_i);
      if (i > 0) begin
        chk("burst_valid", output_valid_o, 1);
        chk("burst_data", reg_data_o, i);
        chk("burst_rd", reg_addr_o, i);
        chk("burst_rw", reg_write_o, 1);
        chk("burst_ready", input_ready_o, 1);
        chk("burst_cyc", wb_cyc_o, 0);
      end
      if (i < 4) begin
        input_valid_i = 1'b1; enable_i = 1'b0; reg_write_i = 1'b1;
        data_i = 32'(i + 1); reg_addr_i = 5'(i + 1);
      end else begin
        input_valid_i = 1'b0;
      end
    end
    @(negedge clk_i);
    chk("burst_end_valid", output_valid_o, 0);

    for (int i = 0; i < 9; i++) run_txn(tbl[i]);

    // Reset while waiting for ack abandons the transaction
    n_vec++;
    @(negedge clk_i);
    input_valid_i = 1'b1; enable_i = 1'b1; write_i = 1'b0; size_i = 2'd2;
    addr_i = 32'h900; reg_addr_i = 5'd9; reg_write_i = 1'b1;
    @(negedge clk_i);
    input_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rstw_cyc_before", wb_cyc_o, 1);
    rst_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h5555_AAAA;
    #1;
    chk("rstw_cyc", wb_cyc_o, 0);
    chk("rstw_stb", wb_stb_o, 0);
    chk("rstw_ready", input_ready_o, 1);
    chk("rstw_valid", output_valid_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1; wb_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("rstw_no_valid", output_valid_o, 0);
      chk("rstw_idle_cyc", wb_cyc_o, 0);
    end
    run_txn(mk(0, 0, 2'd2, 32'h904, 32'h0, 32'h0BAD_F00D, 0, 0, 4'b1111, 32'h904, 32'h0, 32'h0BAD_F00D));

`ifdef LSM_MISALIGN_EXC_EN
    // Misaligned word load raises an exception without a bus cycle
    n_vec++;
    @(negedge clk_i);
    input_valid_i = 1'b1; enable_i = 1'b1; write_i = 1'b0; size_i = 2'd2;
    addr_i = 32'h101; reg_addr_i = 5'd3; reg_write_i = 1'b1;
    @(negedge clk_i);
    input_valid_i = 1'b0;
    chk("mis_valid", output_valid_o, 1);
    chk("mis_flag", misaligned_o, 1);
    chk("mis_addr", exc_addr_o, 32'h101);
    chk("mis_rw", reg_write_o, 0);
    chk("mis_cyc", wb_cyc_o, 0);
    chk("mis_stb", wb_stb_o, 0);
    @(negedge clk_i);
    chk("mis_flag_end", misaligned_o, 0);
    chk("mis_valid_end", output_valid_o, 0);
    chk("mis_cyc_end", wb_cyc_o, 0);
`endif

    // Randomized mix against the behavioural model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        run_alu($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end else begin
        rv.wr = 1'($urandom_range(0, 1));
        rv.sext = 1'($urandom_range(0, 1));
        rv.size = 2'($urandom_range(0, 3));
        rv.addr = $urandom;
`ifdef LSM_MISALIGN_EXC_EN
        if (rv.size == 2'd1) rv.addr[0] = 1'b0;
        if (rv.size[1]) rv.addr[1:0] = 2'b00;
`endif
        rv.data = $urandom;
        rv.rdat = $urandom;
        rv.rd = 5'($urandom_range(0, 31));
        rv.nstall = $urandom_range(0, 3);
        rv.dly = $urandom_range(0, 3);
        rv.noise = 1'b1;
        rv.e_sel = m_sel(rv.size, rv.addr);
        rv.e_adr = rv.addr & 32'hFFFF_FFFC;
        rv.e_dat = m_wdat(rv.size, rv.data);
        rv.e_reg = m_load(rv.size, rv.addr, rv.sext, rv.rdat);
        rv.e_rw = !rv.wr;
        run_txn(rv);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
